// File: rtl/dither_pkg.sv
// Shared constants and types for the ordered-dither VGA output stage.
package dither_pkg;

    localparam int CHANW = 8;
    localparam int DACW  = 4;

    // Row-major 4x4 Bayer thresholds, index = {iy, ix}.
    localparam logic [3:0] BAYER4 [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    typedef struct packed {
        logic [CHANW-1:0] r;
        logic [CHANW-1:0] g;
        logic [CHANW-1:0] b;
    } rgb8_t;

    function automatic logic [3:0] bayer_thr(input logic [1:0] iy, input logic [1:0] ix);
        return BAYER4[{iy, ix}];
    endfunction

endpackage

// File: rtl/dither_chan.sv
// One colour channel: stage-1 threshold add with carry, stage-2 saturate and blank.
module dither_chan
    import dither_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [CHANW-1:0] i_c,
    input  logic [3:0]       i_thr,
    input  logic             i_de_s1,
    output logic [DACW-1:0]  o_c
);

    logic [CHANW:0]   w_sum;
    logic [CHANW-1:0] r_sum;
    logic             r_sat;
    logic [DACW-1:0]  w_clamp;
    logic [DACW-1:0]  w_out;
    logic [DACW-1:0]  r_out;

    assign w_sum = {1'b0, i_c} + {{(CHANW + 1 - 4){1'b0}}, i_thr};

    // r_sat is the carry of the 9-bit sum; together with r_sum it holds the full result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= '0;
            r_sat <= 1'b0;
        end else begin
            r_sum <= w_sum[CHANW-1:0];
            r_sat <= w_sum[CHANW];
        end
    end

    always_comb begin
        w_clamp = r_sat ? {DACW{1'b1}} : r_sum[CHANW-1 -: DACW];
        w_out   = i_de_s1 ? w_clamp : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_out;
        end
    end

    assign o_c = r_out;

endmodule

// File: rtl/vga_dither.sv
// Ordered-dither VGA output stage, 2-cycle latency; define VGA_DITHER_TEMPORAL_EN
// to rotate the Bayer pattern every frame.
module vga_dither
    import dither_pkg::*;
#(
    parameter int CORDW = 16
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic                    de,
    input  logic                    frame,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic                    dither_en,
    input  logic [CHANW-1:0]        r_in,
    input  logic [CHANW-1:0]        g_in,
    input  logic [CHANW-1:0]        b_in,
    output logic                    vga_hsync,
    output logic                    vga_vsync,
    output logic [DACW-1:0]         vga_r,
    output logic [DACW-1:0]         vga_g,
    output logic [DACW-1:0]         vga_b
);

    logic       r_en_q;
    logic       w_en;
    logic [1:0] w_ix;
    logic [1:0] w_iy;
    logic [3:0] w_thr;
    rgb8_t      w_pix;
    logic       r_de_s1;
    logic       r_hs_s1;
    logic       r_vs_s1;
    logic       r_hs_s2;
    logic       r_vs_s2;
    logic       w_unused;

    assign w_unused = ^{sx[CORDW-1:2], sy[CORDW-1:2]};
    assign w_pix    = {r_in, g_in, b_in};

    // The frame-start pixel already runs in the newly latched mode.
    assign w_en = frame ? dither_en : r_en_q;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_en_q <= 1'b0;
        end else if (frame) begin
            r_en_q <= dither_en;
        end
    end

`ifdef VGA_DITHER_TEMPORAL_EN
    logic [1:0] r_fcnt;
    logic [1:0] w_fcnt_nxt;

    // Advance only across frames that were already dithered; disabling parks it at 0.
    always_comb begin
        w_fcnt_nxt = r_fcnt;
        if (frame) begin
            if (!dither_en) begin
                w_fcnt_nxt = 2'd0;
            end else if (r_en_q) begin
                w_fcnt_nxt = r_fcnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_fcnt <= 2'd0;
        end else begin
            r_fcnt <= w_fcnt_nxt;
        end
    end

    assign w_ix = sx[1:0] + w_fcnt_nxt;
    assign w_iy = sy[1:0] + w_fcnt_nxt;
`else
    assign w_ix = sx[1:0];
    assign w_iy = sy[1:0];
`endif

    assign w_thr = w_en ? bayer_thr(w_iy, w_ix) : 4'd0;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_de_s1 <= 1'b0;
            r_hs_s1 <= 1'b1;
            r_vs_s1 <= 1'b1;
            r_hs_s2 <= 1'b1;
            r_vs_s2 <= 1'b1;
        end else begin
            r_de_s1 <= de;
            r_hs_s1 <= hsync;
            r_vs_s1 <= vsync;
            r_hs_s2 <= r_hs_s1;
            r_vs_s2 <= r_vs_s1;
        end
    end

    assign vga_hsync = r_hs_s2;
    assign vga_vsync = r_vs_s2;

    dither_chan u_chan_r (
        .i_clk   (clk_pix),
        .i_rst_n (rst_pix_n),
        .i_c     (w_pix.r),
        .i_thr   (w_thr),
        .i_de_s1 (r_de_s1),
        .o_c     (vga_r)
    );

    dither_chan u_chan_g (
        .i_clk   (clk_pix),
        .i_rst_n (rst_pix_n),
        .i_c     (w_pix.g),
        .i_thr   (w_thr),
        .i_de_s1 (r_de_s1),
        .o_c     (vga_g)
    );

    dither_chan u_chan_b (
        .i_clk   (clk_pix),
        .i_rst_n (rst_pix_n),
        .i_c     (w_pix.b),
        .i_thr   (w_thr),
        .i_de_s1 (r_de_s1),
        .o_c     (vga_b)
    );

endmodule

// File: tb/tb_vga_dither.sv
// Self-checking bench for vga_dither: hand vectors, corner sequences, random vs. model.
module tb_vga_dither;

    logic               clk_pix;
    logic               rst_pix_n;
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    logic               de;
    logic               frame;
    logic               hsync;
    logic               vsync;
    logic               dither_en;
    logic [7:0]         r_in;
    logic [7:0]         g_in;
    logic [7:0]         b_in;
    logic               vga_hsync;
    logic               vga_vsync;
    logic [3:0]         vga_r;
    logic [3:0]         vga_g;
    logic [3:0]         vga_b;

    vga_dither #(.CORDW(16)) dut (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .sx        (sx),
        .sy        (sy),
        .de        (de),
        .frame     (frame),
        .hsync     (hsync),
        .vsync     (vsync),
        .dither_en (dither_en),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    typedef struct {
        int   sx;
        int   sy;
        bit   de;
        bit   frame;
        bit   hs;
        bit   vs;
        bit   den;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } in_t;

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    int    n_vec = 0;
    int    n_err = 0;
    int    bay[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
    int    men = 0;
    int    mfcnt = 0;
    out_t  d1, d2, rst_o, dummy;
    string nm_d1, nm_d2;
    vec_t  tab[11];

    function automatic in_t mk(int x, int y, bit e, bit f, bit h, bit v, bit en,
                               logic [7:0] r, logic [7:0] g, logic [7:0] b);
        in_t t;
        t.sx = x; t.sy = y; t.de = e; t.frame = f; t.hs = h; t.vs = v; t.den = en;
        t.r = r; t.g = g; t.b = b;
        return t;
    endfunction

    function automatic out_t mko(int r, int g, int b, bit h, bit v);
        out_t o;
        o.r = 4'(r); o.g = 4'(g); o.b = 4'(b); o.hs = h; o.vs = v;
        return o;
    endfunction

    function automatic int chan(int c, int t, bit e);
        int s;
        if (!e) return 0;
        s = c + t;
        return (s > 255) ? 15 : s / 16;
    endfunction

    // Reference: mode and frame offset are decided first, then the pixel is dithered.
    task automatic model_step(input in_t v, output out_t o);
        int off, ix, iy, t;
        if (v.frame) begin
            if (!v.den) mfcnt = 0;
            else if (men != 0) mfcnt = (mfcnt + 1) % 4;
            men = v.den ? 1 : 0;
        end
        off = 0;
`ifdef VGA_DITHER_TEMPORAL_EN
        off = mfcnt;
`endif
        ix = ((v.sx % 4) + off) % 4;
        iy = ((v.sy % 4) + off) % 4;
        t  = (men != 0) ? bay[iy][ix] : 0;
        o  = mko(chan(int'(v.r), t, v.de), chan(int'(v.g), t, v.de),
                 chan(int'(v.b), t, v.de), v.hs, v.vs);
    endtask

    task automatic check(input string nm, input out_t e);
        n_vec++;
        if (vga_r !== e.r || vga_g !== e.g || vga_b !== e.b ||
            vga_hsync !== e.hs || vga_vsync !== e.vs) begin
            n_err++;
            $display("FAIL %s: got rgb=%h/%h/%h hs=%b vs=%b, want rgb=%h/%h/%h hs=%b vs=%b",
                     nm, vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
                     e.r, e.g, e.b, e.hs, e.vs);
        end
    endtask

    task automatic apply(input in_t v);
        sx = 16'(v.sx); sy = 16'(v.sy); de = v.de; frame = v.frame;
        hsync = v.hs; vsync = v.vs; dither_en = v.den;
        r_in = v.r; g_in = v.g; b_in = v.b;
    endtask

    // Called at a negedge: check the pixel applied two cycles ago, then apply a new one.
    task automatic cycle(input in_t v, input out_t e, input string nm);
        check(nm_d2, d2);
        d2 = d1; nm_d2 = nm_d1;
        d1 = e;  nm_d1 = nm;
        apply(v);
        @(negedge clk_pix);
    endtask

    task automatic run_model(input in_t v, input string nm);
        out_t e;
        model_step(v, e);
        cycle(v, e, nm);
    endtask

    task automatic run_hand(input in_t v, input out_t e, input string nm);
        model_step(v, dummy);
        cycle(v, e, nm);
    endtask

    task automatic flush_to_reset(input string nm);
        d1 = rst_o; d2 = rst_o; nm_d1 = nm; nm_d2 = nm;
        men = 0; mfcnt = 0;
    endtask

    initial begin
        rst_o = mko(0, 0, 0, 1'b1, 1'b1);

        tab[0].i  = mk(0, 0, 1, 1, 1, 1, 1, 8'h88, 8'h00, 8'hFF); tab[0].o  = mko(8, 0, 15, 1, 1);
        tab[1].i  = mk(1, 0, 1, 0, 0, 1, 1, 8'h88, 8'h88, 8'h07); tab[1].o  = mko(9, 9, 0, 0, 1);
        tab[2].i  = mk(0, 3, 1, 0, 1, 0, 1, 8'h07, 8'hFF, 8'h00); tab[2].o  = mko(1, 15, 0, 1, 0);
        tab[3].i  = mk(3, 1, 1, 0, 0, 0, 1, 8'hFA, 8'hF9, 8'h0A); tab[3].o  = mko(15, 15, 1, 0, 0);
        tab[4].i  = mk(2, 1, 0, 0, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF); tab[4].o  = mko(0, 0, 0, 1, 1);
        tab[5].i  = mk(2, 2, 1, 0, 1, 0, 1, 8'h0F, 8'h0E, 8'h80); tab[5].o  = mko(1, 0, 8, 1, 0);
        tab[6].i  = mk(1, 3, 1, 0, 0, 1, 1, 8'h79, 8'h78, 8'hF8); tab[6].o  = mko(8, 7, 15, 0, 1);
        tab[7].i  = mk(0, 0, 1, 1, 1, 1, 0, 8'h88, 8'h00, 8'h00); tab[7].o  = mko(8, 0, 0, 1, 1);
        tab[8].i  = mk(1, 0, 1, 0, 1, 1, 1, 8'h88, 8'h8F, 8'h01); tab[8].o  = mko(8, 8, 0, 1, 1);
        tab[9].i  = mk(0, 0, 1, 1, 1, 1, 1, 8'h88, 8'h88, 8'h88); tab[9].o  = mko(8, 8, 8, 1, 1);
        tab[10].i = mk(1, 0, 1, 0, 1, 1, 1, 8'h88, 8'hFF, 8'h00); tab[10].o = mko(9, 15, 0, 1, 1);

        rst_pix_n = 1'b0;
        apply(mk(0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00));
        repeat (3) @(negedge clk_pix);
        check("reset_state", rst_o);
        rst_pix_n = 1'b1;
        flush_to_reset("post_reset");

        for (int k = 0; k < 11; k++) begin
            run_hand(tab[k].i, tab[k].o, $sformatf("table%0d", k));
        end

`ifdef VGA_DITHER_TEMPORAL_EN
        run_hand(mk(0, 0, 1, 1, 1, 1, 0, 8'h8C, 8'h00, 8'h00), mko(8, 0, 0, 1, 1), "tmp_off");
        run_hand(mk(0, 0, 1, 1, 1, 1, 1, 8'h8C, 8'h00, 8'h00), mko(8, 0, 0, 1, 1), "tmp_f0");
        run_hand(mk(0, 0, 1, 1, 1, 1, 1, 8'h8C, 8'h00, 8'h00), mko(9, 0, 0, 1, 1), "tmp_f1");
`endif

        for (int k = 0; k < 400; k++) begin
            in_t v;
            v = mk(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
                   bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 15) == 0),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 8'($urandom));
            run_model(v, "random");
        end

        // Fill the pipe with bright pixels and active syncs, then reset between edges.
        for (int k = 0; k < 3; k++) begin
            run_model(mk(k, 5, 1, 0, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF), "pre_reset");
        end
        #2 rst_pix_n = 1'b0;
        #1 check("async_reset", rst_o);
        @(negedge clk_pix);
        rst_pix_n = 1'b1;
        flush_to_reset("reset_release");

        run_hand(mk(1, 0, 1, 0, 1, 1, 1, 8'h88, 8'h88, 8'h88), mko(8, 8, 8, 1, 1), "rel_trunc");
        run_hand(mk(0, 0, 1, 1, 1, 1, 1, 8'h88, 8'h88, 8'h88), mko(8, 8, 8, 1, 1), "rel_frame");
        run_hand(mk(1, 0, 1, 0, 0, 1, 1, 8'h88, 8'h88, 8'h88), mko(9, 9, 9, 0, 1), "rel_dither");
        run_model(mk(2, 0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h00), "drain0");
        run_model(mk(3, 0, 0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h00), "drain1");
        run_model(mk(4, 0, 0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h00), "drain2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_dither.md
# vga_dither

Ordered-dither output stage for the 8-bit-per-channel colour path. It converts each channel to the 4-bit VGA DAC width using a 4×4 Bayer threshold matrix instead of plain truncation, and delays hsync/vsync to stay aligned with colour. It sits directly downstream of the paint/blanking logic, on `clk_pix`. Its registered outputs drive the `vga_*` pins, replacing the existing truncating output register.

## Interface
Parameters:
- `CORDW`, 16: signed screen coordinate width; must match the display timing generator.

Ports:
- `clk_pix`, in, 1: pixel clock.
- `rst_pix_n`, in, 1: asynchronous, active-low reset.
- `sx`, in, CORDW signed: horizontal screen position of the current input pixel.
- `sy`, in, CORDW signed: vertical screen position of the current input pixel.
- `de`, in, 1: data enable; low during blanking.
- `frame`, in, 1: one-cycle pulse at frame start.
- `hsync`, in, 1: horizontal sync, passed through unchanged.
- `vsync`, in, 1: vertical sync, passed through unchanged.
- `dither_en`, in, 1: request dithering; when low, channels are truncated.
- `r_in`, in, 8: red input channel.
- `g_in`, in, 8: green input channel.
- `b_in`, in, 8: blue input channel.
- `vga_hsync`, out, 1: delayed hsync.
- `vga_vsync`, out, 1: delayed vsync.
- `vga_r`, out, 4: red to VGA DAC.
- `vga_g`, out, 4: green to VGA DAC.
- `vga_b`, out, 4: blue to VGA DAC.

## Operation
- Matrix index: `ix = sx[1:0]`, `iy = sy[1:0]`.
- Threshold: `t = BAYER[iy][ix]`, 4-bit. Rows are 0,8,2,10 / 12,4,14,6 / 3,11,1,9 / 15,7,13,5.
- Per channel: `sum = c + t`, computed 9 bits wide. Output is `15` if `sum > 255`, otherwise `sum[7:4]`.
  - Input 0 always gives 0; input 255 always gives 15.
- Dither-enable latch:
  - `en_q` captures `dither_en` only on the cycle where `frame` is high, so a frame never mixes modes.
  - When `en_q == 0`, `t` is forced to 0, giving pure truncation `c[7:4]`.
- Blanking: when the delayed `de` is low, all colour outputs are 0, whatever the input colour.
- `hsync` and `vsync` are delayed by the same pipeline depth as colour and are never modified.
- Reset values, asserted asynchronously and released synchronously by the user:
  - `vga_r`, `vga_g`, `vga_b` = 0.
  - `vga_hsync`, `vga_vsync` = 1 (inactive for negative-polarity 480p).
  - `en_q` = 0, frame counter = 0, all pipeline registers cleared with `de` = 0.
- Reset mid-frame: outputs return to reset values immediately. On release, `en_q` stays 0 until the next `frame` pulse.

## Timing
- Fixed 2-cycle latency from every input to every output.
- Stage 1 registers the 9-bit sums, saturation flags, delayed `de`, and syncs.
- Stage 2 registers the clamped, blanked 4-bit colours and syncs.
- Throughput is one pixel per clock with no stalls and no handshake.
- A `frame` pulse in cycle n updates `en_q` at the edge ending cycle n. That pixel (sx=0, sy=0 of the new frame) already uses the new mode.
- The integrator compensates by advancing the upstream linebuffer enable by one more cycle than before (LAT_LB + 1).

## Configuration
- `VGA_DITHER_TEMPORAL_EN` defined:
  - A 2-bit frame counter increments on each `frame` pulse and wraps 3→0.
  - Indices become `ix = sx[1:0] + fcnt` and `iy = sy[1:0] + fcnt`, both mod 4.
  - This rotates the pattern frame to frame to reduce visible texture.
- Not defined: no counter exists and indices use `sx`/`sy` directly.
- The counter only advances when `en_q` is 1; it stays at 0 otherwise.

## Structure
- Package `dither_pkg`:
  - `BAYER4` constant, 16 × 4-bit.
  - Localparams `CHANW=8`, `DACW=4`.
  - A `rgb8_t` packed struct.
- Sub-module `dither_chan`: one instance per channel. It contains the stage-1 add/saturate and the stage-2 clamp/blank for a single channel. Threshold and delayed `de` are shared inputs.
- The top of the block holds index calculation, `en_q`, the frame counter, and the sync delay line.

## Test plan
- `en_q=1`, `r_in=0x88`, `sy=0`: at `sx=0` → `vga_r=8`; at `sx=1` (t=8, sum 144) → `vga_r=9`; both appear 2 cycles after input.
- `en_q=1`, input `0xFF` at every position → 15; input `0x00` → 0; input `0x07` at `sx=0,sy=3` (t=15, sum 22) → 1.
- `de=0` with input `0xFF` → colours 0. `hsync`/`vsync` toggles appear on `vga_*sync` exactly 2 cycles later.
- Raise `dither_en` mid-frame → output stays truncated (`0x88` → 8 at `sx=1`) until the next `frame` pulse, after which it is dithered (→ 9).
- With `VGA_DITHER_TEMPORAL_EN`, `en_q=1`, after one frame (fcnt=1), input `0x8C` at `sx=0,sy=0` (t=4, sum 144) → 9. The frame before (t=0) gives 8.
- Assert `rst_pix_n` low mid-line → outputs go to 0/0/0, syncs to 1, without waiting for a clock edge. After release, truncation is used until the first `frame` pulse.
